// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue
// In-order queue of branch predictions issued at fetch. Each entry is compared
// with the real outcome when execute resolves the oldest branch. The queue
// produces registered training feedback for the gshare/BTB predictor and a
// flush/redirect pulse to fetch when a prediction turns out to be wrong.
module branch_resolve_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,

    // prediction push from the predictor
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [31:0]      push_pc,
    input  logic             push_taken,
    input  logic [31:0]      push_target,

    // resolution from execute
    input  logic             res_valid,
    output logic             res_ready,
    input  logic             res_taken,
    input  logic [31:0]      res_target,

    // training feedback to the predictor
    output logic             upd_valid,
    output logic             gin,
    output logic             branch,
    output logic [31:0]      upd_target,

    // flush / redirect to fetch
    output logic             mispredict,
    output logic [31:0]      redirect_pc,

    // status
    output logic [PTR_W:0]   occupancy,
    output logic [CNT_W-1:0] mispredict_count
);

    // One in-flight prediction: where it was fetched, which way we guessed,
    // and where we guessed it would go.
    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } entry_t;

    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    entry_t           entries_q [DEPTH];
    entry_t           entries_d [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   occupancy_q, occupancy_d;

    logic             upd_valid_q, upd_valid_d;
    logic             gin_q, gin_d;
    logic             branch_q, branch_d;
    logic [31:0]      upd_target_q, upd_target_d;
    logic             mispredict_q, mispredict_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

    // ------------------------------------------------------------------
    // Handshake and head-of-queue decode
    // ------------------------------------------------------------------
    logic   full;
    logic   empty;
    logic   push_fire;
    logic   res_fire;
    logic   head_wrong;
    logic   flush;
    entry_t head;
    entry_t push_entry;

    // Ready signals depend only on stored occupancy so execute and the
    // predictor never see a combinational loop through this block.
    always_comb begin
        full       = (occupancy_q == FULL_COUNT);
        empty      = (occupancy_q == '0);
        push_ready = !full;
        res_ready  = !empty;
        push_fire  = push_valid && push_ready;
        res_fire   = res_valid && res_ready;
    end

    // Compare the oldest prediction with what execute actually saw. A taken
    // branch that went somewhere other than the BTB target also counts as a
    // miss, since fetch followed the wrong path.
    always_comb begin
        head       = entries_q[rd_ptr_q];
        push_entry = '{pc: push_pc, taken: push_taken, target: push_target};
        head_wrong = (head.taken != res_taken) ||
                     (head.taken && res_taken && (head.target != res_target));
        flush      = res_fire && head_wrong;
    end

    // ------------------------------------------------------------------
    // Queue bookkeeping: storage writes, pointers and occupancy
    // ------------------------------------------------------------------

    // Next-state for the FIFO. On a flush every younger entry, including a
    // push arriving in the same cycle, is thrown away by pulling wr_ptr back
    // to just behind the head being retired.
    always_comb begin
        entries_d   = entries_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occupancy_d = occupancy_q;

        if (push_fire && !flush) begin
            entries_d[wr_ptr_q] = push_entry;
            wr_ptr_d            = wr_ptr_q + PTR_W'(1);
        end

        if (res_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        if (flush) begin
            wr_ptr_d    = rd_ptr_q + PTR_W'(1);
            occupancy_d = '0;
        end else begin
            case ({push_fire, res_fire})
                2'b10:   occupancy_d = occupancy_q + (PTR_W+1)'(1);
                2'b01:   occupancy_d = occupancy_q - (PTR_W+1)'(1);
                default: occupancy_d = occupancy_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Feedback and flush outputs
    // ------------------------------------------------------------------

    // Pulses fall back to zero every cycle; the data fields only move on an
    // accepted resolve so the predictor can sample them at leisure.
    always_comb begin
        upd_valid_d        = 1'b0;
        mispredict_d       = 1'b0;
        gin_d              = gin_q;
        branch_d           = branch_q;
        upd_target_d       = upd_target_q;
        redirect_pc_d      = redirect_pc_q;
        mispredict_count_d = mispredict_count_q;

        if (res_fire) begin
            upd_valid_d   = 1'b1;
            gin_d         = res_taken;
            branch_d      = res_taken;
            upd_target_d  = res_target;
            redirect_pc_d = res_taken ? res_target : (head.pc + 32'd4);
            mispredict_d  = head_wrong;
        end

        if (flush && (mispredict_count_q != CNT_MAX)) begin
            mispredict_count_d = mispredict_count_q + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // Entry storage is not reset; stale contents are unreachable once the
    // pointers and occupancy are cleared.
    always_ff @(posedge clk) begin
        entries_q <= entries_d;
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q           <= '0;
            rd_ptr_q           <= '0;
            occupancy_q        <= '0;
            upd_valid_q        <= 1'b0;
            gin_q              <= 1'b0;
            branch_q           <= 1'b0;
            upd_target_q       <= '0;
            mispredict_q       <= 1'b0;
            redirect_pc_q      <= '0;
            mispredict_count_q <= '0;
        end else begin
            wr_ptr_q           <= wr_ptr_d;
            rd_ptr_q           <= rd_ptr_d;
            occupancy_q        <= occupancy_d;
            upd_valid_q        <= upd_valid_d;
            gin_q              <= gin_d;
            branch_q           <= branch_d;
            upd_target_q       <= upd_target_d;
            mispredict_q       <= mispredict_d;
            redirect_pc_q      <= redirect_pc_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    // Drive outputs straight from registers.
    always_comb begin
        upd_valid        = upd_valid_q;
        gin              = gin_q;
        branch           = branch_q;
        upd_target       = upd_target_q;
        mispredict       = mispredict_q;
        redirect_pc      = redirect_pc_q;
        occupancy        = occupancy_q;
        mispredict_count = mispredict_count_q;
    end

endmodule
